// File: rtl/uart_rx.sv
// uart_rx: UART receiver that deserialises 8-bit frames and writes each byte into a memory ring.
// Build option: define UART_RX_PARITY_EN for an even-parity bit between the data and stop bits.
module uart_rx #(
   parameter int unsigned M_WIDTH     = 32,
   parameter logic [15:0] DEFAULT_DIV = 16'd868,
   parameter logic [1:0]  MEM_ACC_8   = 2'b00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               reg_req,
   input  logic               reg_we,
   input  logic [1:0]         reg_select,
   input  logic [M_WIDTH-1:0] reg_data_in,
   output logic [M_WIDTH-1:0] reg_data_out,
   output logic               reg_ready,
   output logic               rx_mem_req,
   output logic [M_WIDTH-1:0] rx_mem_addr,
   output logic [1:0]         rx_mem_width,
   output logic [M_WIDTH-1:0] rx_mem_data_out,
   input  logic               rx_mem_ready,
   input  logic               rx
);
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

   state_e             state_q, state_d;
   logic               sync1_q, rxs_q, rxs_prev_q;
   logic [15:0]        cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               par_bad_q, par_bad_d;
   logic               en_q, en_d;
   logic [15:0]        div_q, div_d, buf_len_q, buf_len_d, wr_idx_q, wr_idx_d;
   logic [M_WIDTH-1:0] buf_addr_q, buf_addr_d, mem_addr_q, mem_addr_d, rdata_q, rdata_d;
   logic [7:0]         mem_byte_q, mem_byte_d;
   logic               pending_q, pending_d, ready_q, ready_d;
   logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic               parity_err_q, parity_err_d;

   logic               reg_acc, wr_ctrl, wr_addr, wr_len, wr_status;
   logic [M_WIDTH-1:0] rd_word;
   logic [15:0]        div_eff, idx_inc;
   logic               cnt_exp, mem_hs, byte_done, frame_set, parity_set, overrun_set;

   // Register decode; a held request is accepted only every other cycle.
   always_comb begin
      reg_acc   = reg_req & ~ready_q;
      wr_ctrl   = reg_acc & reg_we & (reg_select == 2'd0);
      wr_addr   = reg_acc & reg_we & (reg_select == 2'd1);
      wr_len    = reg_acc & reg_we & (reg_select == 2'd2);
      wr_status = reg_acc & reg_we & (reg_select == 2'd3);
      rd_word   = '0;
      unique case (reg_select)
         2'd0: begin
            rd_word[31:16] = div_q;
            rd_word[0]     = en_q;
         end
         2'd1: rd_word = buf_addr_q;
         2'd2: rd_word[15:0] = buf_len_q;
         default: begin
            rd_word[15:0] = wr_idx_q;
            rd_word[16]   = overrun_q;
            rd_word[17]   = frame_err_q;
            rd_word[18]   = pending_q;
            rd_word[19]   = parity_err_q;
         end
      endcase
      rdata_d    = (reg_acc & ~reg_we) ? rd_word : '0;
      ready_d    = reg_acc;
      en_d       = wr_ctrl ? reg_data_in[0] : en_q;
      div_d      = wr_ctrl ? reg_data_in[31:16] : div_q;
      buf_addr_d = wr_addr ? reg_data_in : buf_addr_q;
      buf_len_d  = wr_len ? reg_data_in[15:0] : buf_len_q;
   end

   // Receive FSM
   always_comb begin
      div_eff    = (div_q < 16'd4) ? 16'd4 : div_q;
      cnt_exp    = (cnt_q <= 16'd1);
      state_d    = state_q;
      cnt_d      = cnt_exp ? cnt_q : cnt_q - 16'd1;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      byte_done  = 1'b0;
      frame_set  = 1'b0;
      parity_set = 1'b0;
      if (!en_q) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rxs_prev_q & ~rxs_q) begin
                  state_d = StStart;
                  cnt_d   = div_eff >> 1;
               end
            end
            StStart: begin
               if (cnt_exp) begin
                  state_d   = rxs_q ? StIdle : StData;
                  cnt_d     = div_eff;
                  bit_d     = 3'd0;
                  par_bad_d = 1'b0;
               end
            end
            StData: begin
               if (cnt_exp) begin
                  shift_d = {rxs_q, shift_q[7:1]};
                  cnt_d   = div_eff;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (cnt_exp) begin
                  par_bad_d  = (^shift_q) ^ rxs_q;
                  parity_set = (^shift_q) ^ rxs_q;
                  cnt_d      = div_eff;
                  state_d    = StStop;
               end
            end
`endif
            StStop: begin
               if (cnt_exp) begin
                  if (rxs_q) begin
                     byte_done = ~par_bad_q;
                     state_d   = StIdle;
                  end else begin
                     frame_set = 1'b1;
                     state_d   = StWaitHigh;
                  end
               end
            end
            StWaitHigh: begin
               if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Holding register and ring index
   always_comb begin
      mem_hs      = pending_q & rx_mem_ready;
      idx_inc     = wr_idx_q + 16'd1;
      pending_d   = pending_q;
      mem_addr_d  = mem_addr_q;
      mem_byte_d  = mem_byte_q;
      wr_idx_d    = wr_idx_q;
      overrun_set = 1'b0;
      if (mem_hs) begin
         pending_d = 1'b0;
         wr_idx_d  = (idx_inc == buf_len_q) ? 16'd0 : idx_inc;
      end
      if (byte_done && (buf_len_q != 16'd0)) begin
         if (pending_q && !mem_hs) begin
            overrun_set = 1'b1;
         end else begin
            pending_d  = 1'b1;
            mem_byte_d = shift_q;
            mem_addr_d = buf_addr_q + {{(M_WIDTH-16){1'b0}}, wr_idx_d};
         end
      end
      if (wr_addr) wr_idx_d = '0;
      // A flag being set wins over a coincident write-1-clear.
      overrun_d    = (overrun_q & ~(wr_status & reg_data_in[16])) | overrun_set;
      frame_err_d  = (frame_err_q & ~(wr_status & reg_data_in[17])) | frame_set;
      parity_err_d = (parity_err_q & ~(wr_status & reg_data_in[19])) | parity_set;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         sync1_q      <= 1'b1;
         rxs_q        <= 1'b1;
         rxs_prev_q   <= 1'b1;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_bad_q    <= 1'b0;
         en_q         <= 1'b0;
         div_q        <= DEFAULT_DIV;
         buf_addr_q   <= '0;
         buf_len_q    <= '0;
         wr_idx_q     <= '0;
         mem_addr_q   <= '0;
         mem_byte_q   <= '0;
         pending_q    <= 1'b0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= rx;
         rxs_q        <= sync1_q;
         rxs_prev_q   <= rxs_q;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_bad_q    <= par_bad_d;
         en_q         <= en_d;
         div_q        <= div_d;
         buf_addr_q   <= buf_addr_d;
         buf_len_q    <= buf_len_d;
         wr_idx_q     <= wr_idx_d;
         mem_addr_q   <= mem_addr_d;
         mem_byte_q   <= mem_byte_d;
         pending_q    <= pending_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign reg_data_out    = rdata_q;
   assign reg_ready       = ready_q;
   assign rx_mem_req      = pending_q;
   assign rx_mem_addr     = mem_addr_q;
   assign rx_mem_width    = MEM_ACC_8;
   assign rx_mem_data_out = {{(M_WIDTH-8){1'b0}}, mem_byte_q};
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames on rx checked against a ring-buffer model of the expected writes.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
module tb_uart_rx;
   logic        clk = 1'b0;
   logic        rst;
   logic        reg_req, reg_we;
   logic [1:0]  reg_select;
   logic [31:0] reg_data_in, reg_data_out;
   logic        reg_ready;
   logic        rx_mem_req, rx_mem_ready;
   logic [31:0] rx_mem_addr, rx_mem_data_out;
   logic [1:0]  rx_mem_width;
   logic        rx;

   always #5 clk = ~clk;

   uart_rx dut (
      .clk             (clk),
      .rst             (rst),
      .reg_req         (reg_req),
      .reg_we          (reg_we),
      .reg_select      (reg_select),
      .reg_data_in     (reg_data_in),
      .reg_data_out    (reg_data_out),
      .reg_ready       (reg_ready),
      .rx_mem_req      (rx_mem_req),
      .rx_mem_addr     (rx_mem_addr),
      .rx_mem_width    (rx_mem_width),
      .rx_mem_data_out (rx_mem_data_out),
      .rx_mem_ready    (rx_mem_ready),
      .rx              (rx)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_writes = 0;
   bit          hold_ready = 1'b0;
   logic [31:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];
   // Model of the software-visible ring state
   logic [31:0] m_base;
   logic [15:0] m_len, m_idx, m_div;
   int          m_bit;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input bit ov, input bit fe, input bit par);
      return {12'b0, par, 1'b0, fe, ov, m_idx};
   endfunction

   task automatic reg_write(input logic [1:0] sel, input logic [31:0] data);
      @(negedge clk);
      reg_req = 1'b1; reg_we = 1'b1; reg_select = sel; reg_data_in = data;
      @(negedge clk);
      reg_req = 1'b0; reg_we = 1'b0;
   endtask

   task automatic reg_read(input logic [1:0] sel, output logic [31:0] data);
      @(negedge clk);
      reg_req = 1'b1; reg_we = 1'b0; reg_select = sel;
      @(negedge clk);
      reg_req = 1'b0;
      check("reg_ready", {31'b0, reg_ready}, 32'd1);
      data = reg_data_out;
   endtask

   task automatic cfg(input logic [15:0] div, input logic [31:0] base, input logic [15:0] len);
      reg_write(2'd0, {div, 15'b0, 1'b1});
      reg_write(2'd1, base);
      reg_write(2'd2, {16'b0, len});
      m_div = div; m_bit = (div < 16'd4) ? 4 : int'(div);
      m_base = base; m_len = len; m_idx = 16'd0;
   endtask

   // One frame on the line; a good frame with a non-empty ring queues the expected write.
   task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                            input bit exp_write);
      if (exp_write && stop_bit && !par_flip && m_len != 16'd0) begin
         exp_addr_q.push_back(m_base + {16'b0, m_idx});
         exp_data_q.push_back(b);
         m_idx = (m_idx + 16'd1 == m_len) ? 16'd0 : m_idx + 16'd1;
      end
      @(negedge clk);
      rx = 1'b0; repeat (m_bit) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i]; repeat (m_bit) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip; repeat (m_bit) @(negedge clk);
`endif
      rx = stop_bit; repeat (m_bit) @(negedge clk);
      rx = 1'b1; repeat (4) @(negedge clk);
   endtask

   task automatic drain();
      repeat (20) @(negedge clk);
      check("queue_drained", 32'(exp_addr_q.size()), 32'd0);
   endtask

   // Memory client: accepts each request after a random 0..3 cycle delay.
   initial begin
      rx_mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         rx_mem_ready = 1'b0;
         if (rx_mem_req && !hold_ready) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (rx_mem_req && !hold_ready) begin
               n_writes++;
               check("write_expected", {31'b0, exp_addr_q.size() != 0}, 32'd1);
               if (exp_addr_q.size() != 0) begin
                  check("mem_addr", rx_mem_addr, exp_addr_q.pop_front());
                  check("mem_data", rx_mem_data_out, {24'b0, exp_data_q.pop_front()});
               end
               check("mem_width", {30'b0, rx_mem_width}, 32'd0);
               rx_mem_ready = 1'b1;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      int          w0;
      bit          fe;
      rst = 1'b0; reg_req = 1'b0; reg_we = 1'b0; reg_select = 2'd0; reg_data_in = '0;
      rx = 1'b1;
      m_base = '0; m_len = '0; m_idx = '0; m_div = 16'd868; m_bit = 868;
      repeat (3) @(negedge clk);
      check("rst_reg_ready", {31'b0, reg_ready}, 32'd0);
      check("rst_reg_data", reg_data_out, 32'd0);
      check("rst_mem_req", {31'b0, rx_mem_req}, 32'd0);
      check("rst_mem_addr", rx_mem_addr, 32'd0);
      check("rst_mem_data", rx_mem_data_out, 32'd0);
      check("rst_mem_width", {30'b0, rx_mem_width}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      reg_read(2'd0, d); check("ctrl_reset", d, 32'h0364_0000);
      reg_read(2'd1, d); check("bufaddr_reset", d, 32'd0);
      reg_read(2'd2, d); check("buflen_reset", d, 32'd0);
      reg_read(2'd3, d); check("status_reset", d, 32'd0);

      // Basic ring write
      cfg(16'd16, 32'h100, 16'd4);
      reg_read(2'd0, d); check("ctrl_rw", d, 32'h0010_0001);
      send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
      drain();
      check("basic_writes", n_writes, 1);
      reg_read(2'd3, d); check("basic_status", d, exp_status(0, 0, 0));

      // Wrap: BUF_ADDR write restarts the ring
      reg_write(2'd1, 32'h100); m_idx = 16'd0;
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b1);
      drain();
      check("wrap_writes", n_writes, 6);
      reg_read(2'd3, d); check("wrap_status", d, exp_status(0, 0, 0));

      // Random divisors, ring sizes and data, with occasional stop-bit errors
      for (int t = 0; t < 4; t++) begin
         cfg(16'($urandom_range(2, 24)), $urandom, 16'($urandom_range(1, 7)));
         fe = 1'b0;
         for (int i = 0; i < 8; i++) begin
            bit stop_ok;
            stop_ok = ($urandom_range(0, 7) != 0);
            if (!stop_ok) fe = 1'b1;
            send_byte(8'($urandom_range(0, 255)), stop_ok, 1'b0, 1'b1);
         end
         drain();
         reg_read(2'd3, d); check("rand_status", d, exp_status(0, fe, 0));
         reg_write(2'd3, 32'h0002_0000);
      end

      // Overrun: second byte dropped while the first is still pending
      cfg(16'd16, 32'h200, 16'd8);
      hold_ready = 1'b1;
      w0 = n_writes;
      send_byte(8'h11, 1'b1, 1'b0, 1'b1);
      send_byte(8'h22, 1'b1, 1'b0, 1'b0);
      reg_read(2'd3, d); check("ovr_flags_held", {12'b0, d[31:12]}, 32'h0000_0050);
      hold_ready = 1'b0;
      drain();
      check("ovr_writes", n_writes, w0 + 1);
      reg_read(2'd3, d); check("ovr_status", d, exp_status(1, 0, 0));
      reg_write(2'd3, 32'h0001_0000);
      reg_read(2'd3, d); check("ovr_cleared", d, exp_status(0, 0, 0));

      // Framing error, then W1C
      w0 = n_writes;
      send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
      drain();
      check("fe_no_write", n_writes, w0);
      reg_read(2'd3, d); check("fe_status", d, exp_status(0, 1, 0));
      reg_write(2'd3, 32'h0002_0000);
      reg_read(2'd3, d); check("fe_cleared", d, exp_status(0, 0, 0));

      // Short glitch is a false start; next frame is received normally
      @(negedge clk);
      rx = 1'b0; repeat (3) @(negedge clk);
      rx = 1'b1; repeat (3 * m_bit) @(negedge clk);
      check("glitch_no_write", n_writes, w0);
      reg_read(2'd3, d); check("glitch_status", d, exp_status(0, 0, 0));
      send_byte(8'h96, 1'b1, 1'b0, 1'b1);
      drain();
      check("glitch_next_write", n_writes, w0 + 1);

      // Empty ring drops bytes silently
      reg_write(2'd2, 32'd0); m_len = 16'd0;
      send_byte(8'h44, 1'b1, 1'b0, 1'b1);
      drain();
      check("len0_no_write", n_writes, w0 + 1);
      reg_read(2'd3, d); check("len0_status", d, exp_status(0, 0, 0));
      reg_write(2'd2, 32'd8); m_len = 16'd8;

      // Disable mid-frame
      fork
         send_byte(8'h77, 1'b1, 1'b0, 1'b0);
         begin
            repeat (5 * m_bit) @(negedge clk);
            reg_write(2'd0, {m_div, 16'h0000});
         end
      join
      drain();
      check("dis_no_write", n_writes, w0 + 1);
      reg_read(2'd3, d); check("dis_status", d, exp_status(0, 0, 0));
      reg_write(2'd0, {m_div, 16'h0001});
      send_byte(8'hE1, 1'b1, 1'b0, 1'b1);
      drain();
      check("reen_write", n_writes, w0 + 2);

`ifdef UART_RX_PARITY_EN
      send_byte(8'h03, 1'b1, 1'b1, 1'b1);
      drain();
      check("par_no_write", n_writes, w0 + 2);
      reg_read(2'd3, d); check("par_status", d, exp_status(0, 0, 1));
      reg_write(2'd3, 32'h0008_0000);
      send_byte(8'h03, 1'b1, 1'b0, 1'b1);
      drain();
      check("par_ok_write", n_writes, w0 + 3);
      reg_read(2'd3, d); check("par_cleared", d, exp_status(0, 0, 0));
`endif

      // Reset during DATA with a write outstanding
      cfg(16'd16, 32'h300, 16'd4);
      hold_ready = 1'b1;
      w0 = n_writes;
      send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
      check("pre_rst_req", {31'b0, rx_mem_req}, 32'd1);
      check("pre_rst_addr", rx_mem_addr, 32'h300);
      check("pre_rst_data", rx_mem_data_out, 32'h5A);
      fork
         send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
         begin
            repeat (4 * m_bit) @(negedge clk);
            rst = 1'b0;
            #1;
            check("mid_rst_req", {31'b0, rx_mem_req}, 32'd0);
            check("mid_rst_addr", rx_mem_addr, 32'd0);
            check("mid_rst_data", rx_mem_data_out, 32'd0);
            check("mid_rst_ready", {31'b0, reg_ready}, 32'd0);
            @(negedge clk);
            rst = 1'b1;
         end
      join
      hold_ready = 1'b0;
      m_base = '0; m_len = '0; m_idx = '0; m_div = 16'd868;
      repeat (20) @(negedge clk);
      check("post_rst_no_write", n_writes, w0);
      reg_read(2'd0, d); check("post_rst_ctrl", d, 32'h0364_0000);
      reg_read(2'd1, d); check("post_rst_bufaddr", d, 32'd0);
      reg_read(2'd3, d); check("post_rst_status", d, exp_status(0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
